sdram_arbiter: RTL and testbench

- Shares the single 8-bit SDRAM port (the sdram controller's din/addr/we/oe/dout, synced to clkref F14M) between three requesters:
  - data_io ROM download (write-only)
  - VTL chip video fetch (read-only)
  - Z80 CPU (read/write)
- Replaces the static dio_download mux in front of the sdram controller.
- Serialises accesses, holds strobes for a fixed slot, returns read data with a one-cycle ack.

---
 rtl/sdram_arb_pkg.sv | 27 ++
 rtl/sdram_arbiter_if.sv | 75 +++++++
 rtl/sdram_arb_prio.sv | 43 ++++
 rtl/sdram_arbiter.sv | 219 +++++++++++++++++++++
 tb/tb_sdram_arbiter.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/sdram_arb_pkg.sv
// -----------------------------------------------------------------------------
// sdram_arb_pkg
//
// Shared types and default parameters for the SDRAM port arbiter.
//   state_t : arbiter FSM state (IDLE -> ACCESS -> DONE -> IDLE)
//   owner_t : which requester owns the current SDRAM slot
//   ACCESS_CYCLES_DEF : default number of F14M cycles a strobe is held
//   STARVE_MAX_DEF    : default CPU-loss count before the CPU is forced in
// -----------------------------------------------------------------------------
package sdram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        OWN_DIO = 2'd0,
        OWN_VID = 2'd1,
        OWN_CPU = 2'd2
    } owner_t;

    localparam int ACCESS_CYCLES_DEF = 4;
    localparam int STARVE_MAX_DEF    = 8;

endpackage

// File: rtl/sdram_arbiter_if.sv
// -----------------------------------------------------------------------------
// sdram_arbiter_if
//
// Bundles the three requester ports and the SDRAM controller port of the
// arbiter.
//   dio_*  : ROM download write port (req/addr/din in, ack out)
//   vid_*  : video read port (req/addr in, ack out)
//   cpu_*  : CPU read/write port (req/wr/addr/din in, ack out)
//   rd_data: read data for video and CPU, valid in the ack cycle
//   sd_*   : SDRAM controller addr/din/we/oe out, dout in
//   busy   : arbiter is in ACCESS or DONE
//
// Handshake: each req is a level held by its requester until the matching
// ack pulses for one cycle; the requester drops req in the cycle after the
// ack. A req still high when the arbiter is back in IDLE starts a new access.
//
// Modports:
//   slave  : the arbiter side
//   master : the requesters plus the SDRAM controller (bench side)
// -----------------------------------------------------------------------------
interface sdram_arbiter_if #(
    parameter int ADDR_W = 25
);
    logic              dio_req;
    logic [ADDR_W-1:0] dio_addr;
    logic [7:0]        dio_din;
    logic              dio_ack;

    logic              vid_req;
    logic [ADDR_W-1:0] vid_addr;
    logic              vid_ack;

    logic              cpu_req;
    logic              cpu_wr;
    logic [ADDR_W-1:0] cpu_addr;
    logic [7:0]        cpu_din;
    logic              cpu_ack;

    logic [7:0]        rd_data;

    logic [ADDR_W-1:0] sd_addr;
    logic [7:0]        sd_din;
    logic              sd_we;
    logic              sd_oe;
    logic [7:0]        sd_dout;

    logic              busy;

    modport slave (
        input  dio_req, dio_addr, dio_din,
        output dio_ack,
        input  vid_req, vid_addr,
        output vid_ack,
        input  cpu_req, cpu_wr, cpu_addr, cpu_din,
        output cpu_ack,
        output rd_data,
        output sd_addr, sd_din, sd_we, sd_oe,
        input  sd_dout,
        output busy
    );

    modport master (
        output dio_req, dio_addr, dio_din,
        input  dio_ack,
        output vid_req, vid_addr,
        input  vid_ack,
        output cpu_req, cpu_wr, cpu_addr, cpu_din,
        input  cpu_ack,
        input  rd_data,
        input  sd_addr, sd_din, sd_we, sd_oe,
        output sd_dout,
        input  busy
    );

endinterface

// File: rtl/sdram_arb_prio.sv
// -----------------------------------------------------------------------------
// sdram_arb_prio
//
// Combinational priority encoder for the SDRAM arbiter.
// Fixed order dio > vid > cpu. When force_cpu is set (starvation guard) a
// pending CPU request jumps ahead of video, but never ahead of download.
//
// Ports:
//   dio_req, vid_req, cpu_req : in  request levels
//   force_cpu                 : in  starvation override for the CPU
//   owner                     : out winning requester
//   valid                     : out at least one request is pending
// -----------------------------------------------------------------------------
module sdram_arb_prio
    import sdram_arb_pkg::*;
(
    input  logic   dio_req,
    input  logic   vid_req,
    input  logic   cpu_req,
    input  logic   force_cpu,
    output owner_t owner,
    output logic   valid
);

    always_comb begin
        owner = OWN_DIO;
        valid = 1'b0;
        if (dio_req) begin
            owner = OWN_DIO;
            valid = 1'b1;
        end else if (force_cpu && cpu_req) begin
            owner = OWN_CPU;
            valid = 1'b1;
        end else if (vid_req) begin
            owner = OWN_VID;
            valid = 1'b1;
        end else if (cpu_req) begin
            owner = OWN_CPU;
            valid = 1'b1;
        end
    end

endmodule

// File: rtl/sdram_arbiter.sv
// -----------------------------------------------------------------------------
// sdram_arbiter
//
// Shares the single 8-bit SDRAM controller port between ROM download (write
// only), video fetch (read only) and the Z80 CPU (read/write). One access at
// a time: a winner is picked in IDLE, its address/data/direction are latched,
// the strobe is held for ACCESS_CYCLES cycles, then the owner gets a
// one-cycle ack in DONE (with rd_data valid for reads).
//
// Timing for a request seen in IDLE at cycle n:
//   n+1 .. n+ACCESS_CYCLES : sd_we or sd_oe high, sd_addr/sd_din stable
//   n+ACCESS_CYCLES+1      : DONE, ack pulse, rd_data updated for reads
//   n+ACCESS_CYCLES+2      : IDLE, next grant possible
//
// Optional build macro SDRAM_ARB_STARVE_EN: adds a 4-bit counter of CPU
// losses; at STARVE_MAX the pending CPU request beats video (not download).
// Without it the priority is purely fixed and a held vid_req or dio_req can
// block the CPU indefinitely.
//
// Ports:
//   F14M      : in  clock, everything on posedge
//   RESET     : in  synchronous active-high reset
//   bus       : requester + SDRAM signals (sdram_arbiter_if.slave)
//   dbg_state : out current FSM state
// -----------------------------------------------------------------------------
module sdram_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int ADDR_W        = 25,
    parameter int ACCESS_CYCLES = ACCESS_CYCLES_DEF,
    parameter int STARVE_MAX    = STARVE_MAX_DEF
) (
    input  logic           F14M,
    input  logic           RESET,
    sdram_arbiter_if.slave bus,
    output state_t         dbg_state
);

    // Counter width follows ACCESS_CYCLES; it counts down from
    // ACCESS_CYCLES-1 to 0 so that ACCESS lasts exactly ACCESS_CYCLES cycles.
    localparam int               CNT_W    = $clog2(ACCESS_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ACCESS_CYCLES - 1);

    // Elaboration-time parameter sanity checks.
    if (ACCESS_CYCLES < 2) begin : g_bad_access_cycles
        $error("ACCESS_CYCLES must be at least 2");
    end
    if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_bad_starve_max
        $error("STARVE_MAX must fit the 4-bit starvation counter (1..15)");
    end

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  cnt;

    owner_t            owner_q;
    logic              wr_q;
    logic [ADDR_W-1:0] addr_q;
    logic [7:0]        din_q;
    logic [7:0]        rd_q;

    owner_t            win_owner;
    logic              win_valid;
    logic              force_cpu;
    logic              grant;

    logic              sd_we_c;
    logic              sd_oe_c;
    logic              busy_c;
    logic              dio_ack_c;
    logic              vid_ack_c;
    logic              cpu_ack_c;

    // -------------------------------------------------------------------------
    // Winner selection (only acted on in IDLE)
    // -------------------------------------------------------------------------
    sdram_arb_prio u_prio (
        .dio_req   (bus.dio_req),
        .vid_req   (bus.vid_req),
        .cpu_req   (bus.cpu_req),
        .force_cpu (force_cpu),
        .owner     (win_owner),
        .valid     (win_valid)
    );

    assign grant = (state == IDLE) && win_valid;

`ifdef SDRAM_ARB_STARVE_EN
    // Counts IDLE decisions the CPU lost while requesting. Saturates at the
    // limit so a CPU that keeps losing to download stays forced ahead of video
    // until it is finally granted.
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    logic [3:0] starve_cnt;

    assign force_cpu = bus.cpu_req && (starve_cnt == STARVE_LIM);

    always_ff @(posedge F14M) begin
        if (RESET) begin
            starve_cnt <= 4'd0;
        end else if (grant) begin
            if (win_owner == OWN_CPU) begin
                starve_cnt <= 4'd0;
            end else if (bus.cpu_req && (starve_cnt != STARVE_LIM)) begin
                starve_cnt <= starve_cnt + 4'd1;
            end
        end
    end
`else
    assign force_cpu = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge F14M) begin
        if (RESET) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next state
    // -------------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (win_valid) state_nxt = ACCESS;
            ACCESS:  if (cnt == '0) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Datapath: latch the winner's request at grant, count the slot, capture
    // read data on the last ACCESS cycle.
    // -------------------------------------------------------------------------
    always_ff @(posedge F14M) begin
        if (RESET) begin
            cnt     <= '0;
            owner_q <= OWN_DIO;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            din_q   <= 8'h00;
            rd_q    <= 8'h00;
        end else begin
            if (grant) begin
                cnt     <= CNT_LOAD;
                owner_q <= win_owner;
                case (win_owner)
                    OWN_DIO: begin
                        wr_q   <= 1'b1;
                        addr_q <= bus.dio_addr;
                        din_q  <= bus.dio_din;
                    end
                    OWN_VID: begin
                        wr_q   <= 1'b0;
                        addr_q <= bus.vid_addr;
                        din_q  <= 8'h00;
                    end
                    default: begin
                        wr_q   <= bus.cpu_wr;
                        addr_q <= bus.cpu_addr;
                        din_q  <= bus.cpu_din;
                    end
                endcase
            end else if ((state == ACCESS) && (cnt != '0)) begin
                cnt <= cnt - CNT_W'(1);
            end

            // Last ACCESS cycle of a read: sd_dout is valid and lands in
            // rd_data for the DONE (ack) cycle, then holds.
            if ((state == ACCESS) && (cnt == '0) && !wr_q) begin
                rd_q <= bus.sd_dout;
            end
        end
    end

    // -------------------------------------------------------------------------
    // FSM: outputs
    // -------------------------------------------------------------------------
    always_comb begin
        sd_we_c   = 1'b0;
        sd_oe_c   = 1'b0;
        busy_c    = 1'b0;
        dio_ack_c = 1'b0;
        vid_ack_c = 1'b0;
        cpu_ack_c = 1'b0;
        case (state)
            ACCESS: begin
                sd_we_c = wr_q;
                sd_oe_c = !wr_q;
                busy_c  = 1'b1;
            end
            DONE: begin
                busy_c    = 1'b1;
                dio_ack_c = (owner_q == OWN_DIO);
                vid_ack_c = (owner_q == OWN_VID);
                cpu_ack_c = (owner_q == OWN_CPU);
            end
            default: ;
        endcase
    end

    assign bus.sd_we   = sd_we_c;
    assign bus.sd_oe   = sd_oe_c;
    assign bus.busy    = busy_c;
    assign bus.dio_ack = dio_ack_c;
    assign bus.vid_ack = vid_ack_c;
    assign bus.cpu_ack = cpu_ack_c;
    assign bus.sd_addr = addr_q;
    assign bus.sd_din  = din_q;
    assign bus.rd_data = rd_q;
    assign dbg_state   = state;

endmodule

// File: tb/tb_sdram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sdram_arbiter
//
// Self-checking bench for sdram_arbiter. A per-cycle vector table covers
// reset, a CPU read, a download write and a simultaneous video/CPU request;
// hand-written sequences cover reset during an access, download blocking the
// CPU, and the video/CPU grant pattern (with or without SDRAM_ARB_STARVE_EN).
// The SDRAM is modelled by a small read function driving sd_dout.
// -----------------------------------------------------------------------------
module tb_sdram_arbiter;
    import sdram_arb_pkg::*;

    localparam int ADDR_W = 25;

    // ---------------------------------------------------------------- clock/reset
    logic   F14M;
    logic   RESET;
    state_t dbg_state;

    initial F14M = 1'b0;
    always #5 F14M = ~F14M;

    sdram_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

    sdram_arbiter #(
        .ADDR_W        (ADDR_W),
        .ACCESS_CYCLES (4),
        .STARVE_MAX    (8)
    ) dut (
        .F14M      (F14M),
        .RESET     (RESET),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // SDRAM content model: one known location, everything else a simple hash.
    function automatic logic [7:0] mem_rd(input logic [ADDR_W-1:0] a);
        if (a == 25'h00066C8) return 8'hA5;
        return a[7:0] ^ 8'h5A;
    endfunction

    assign bus.sd_dout = mem_rd(bus.sd_addr);

    // ---------------------------------------------------------------- counters
    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One clock: outputs are sampled 1 time unit after the rising edge, and
    // the strobes must never be high together.
    task automatic step();
        @(posedge F14M);
        #1;
        chk("we_oe_exclusive", {31'd0, bus.sd_we & bus.sd_oe}, 32'd0);
    endtask

    // ---------------------------------------------------------------- vectors
    typedef struct {
        logic              rst, dio, vid, cpu, wr;
        logic              e_we, e_oe, e_dack, e_vack, e_cack, e_busy;
        logic [7:0]        e_rd;
        logic [ADDR_W-1:0] e_addr;
        logic [7:0]        e_din;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(
        input logic rst, dio, vid, cpu, wr,
        input logic we, oe, dack, vack, cack, busy,
        input logic [7:0] rd, input logic [ADDR_W-1:0] addr, input logic [7:0] din);
        vec_t v;
        v.rst = rst;  v.dio = dio;  v.vid = vid;  v.cpu = cpu;  v.wr = wr;
        v.e_we = we;  v.e_oe = oe;  v.e_dack = dack; v.e_vack = vack;
        v.e_cack = cack; v.e_busy = busy;
        v.e_rd = rd;  v.e_addr = addr; v.e_din = din;
        return v;
    endfunction

    // Scoreboard of expected ack owners for the grant-pattern sequence.
    logic [1:0] exp_q[$];

    // ---------------------------------------------------------------- stimulus
    initial begin
        int k;
        int dio_acks;
        int cpu_seen;
        int ack_seen;
        logic [1:0] got;
        logic [1:0] want;

        RESET        = 1'b1;
        bus.dio_req  = 1'b0;
        bus.dio_addr = 25'h0000100;
        bus.dio_din  = 8'h3C;
        bus.vid_req  = 1'b0;
        bus.vid_addr = 25'h0000200;
        bus.cpu_req  = 1'b0;
        bus.cpu_wr   = 1'b0;
        bus.cpu_addr = 25'h00066C8;
        bus.cpu_din  = 8'h99;

        // Each row: inputs applied before an edge, outputs expected after it.
        //              rst d v c wr  we oe da va ca bsy  rd      addr         din
        tbl.push_back(mk(1, 0,0,0,0,  0, 0, 0, 0, 0, 0,   8'h00, 25'h0000000, 8'h00));
        tbl.push_back(mk(0, 0,0,0,0,  0, 0, 0, 0, 0, 0,   8'h00, 25'h0000000, 8'h00));
        // CPU read of 0x0066C8: strobe 4 cycles, ack with 0xA5 on the 5th
        tbl.push_back(mk(0, 0,0,1,0,  0, 1, 0, 0, 0, 1,   8'h00, 25'h00066C8, 8'h99));
        tbl.push_back(mk(0, 0,0,1,0,  0, 1, 0, 0, 0, 1,   8'h00, 25'h00066C8, 8'h99));
        tbl.push_back(mk(0, 0,0,1,0,  0, 1, 0, 0, 0, 1,   8'h00, 25'h00066C8, 8'h99));
        tbl.push_back(mk(0, 0,0,1,0,  0, 1, 0, 0, 0, 1,   8'h00, 25'h00066C8, 8'h99));
        tbl.push_back(mk(0, 0,0,1,0,  0, 0, 0, 0, 1, 1,   8'hA5, 25'h00066C8, 8'h99));
        tbl.push_back(mk(0, 0,0,0,0,  0, 0, 0, 0, 0, 0,   8'hA5, 25'h00066C8, 8'h99));
        // Download write of 0x3C to 0x000100; rd_data untouched
        tbl.push_back(mk(0, 1,0,0,0,  1, 0, 0, 0, 0, 1,   8'hA5, 25'h0000100, 8'h3C));
        tbl.push_back(mk(0, 1,0,0,0,  1, 0, 0, 0, 0, 1,   8'hA5, 25'h0000100, 8'h3C));
        tbl.push_back(mk(0, 1,0,0,0,  1, 0, 0, 0, 0, 1,   8'hA5, 25'h0000100, 8'h3C));
        tbl.push_back(mk(0, 1,0,0,0,  1, 0, 0, 0, 0, 1,   8'hA5, 25'h0000100, 8'h3C));
        tbl.push_back(mk(0, 1,0,0,0,  0, 0, 1, 0, 0, 1,   8'hA5, 25'h0000100, 8'h3C));
        tbl.push_back(mk(0, 0,0,0,0,  0, 0, 0, 0, 0, 0,   8'hA5, 25'h0000100, 8'h3C));
        // Video and CPU together: video first (ack +5), CPU next (ack +11)
        tbl.push_back(mk(0, 0,1,1,0,  0, 1, 0, 0, 0, 1,   8'hA5, 25'h0000200, 8'h00));
        tbl.push_back(mk(0, 0,1,1,0,  0, 1, 0, 0, 0, 1,   8'hA5, 25'h0000200, 8'h00));
        tbl.push_back(mk(0, 0,1,1,0,  0, 1, 0, 0, 0, 1,   8'hA5, 25'h0000200, 8'h00));
        tbl.push_back(mk(0, 0,1,1,0,  0, 1, 0, 0, 0, 1,   8'hA5, 25'h0000200, 8'h00));
        tbl.push_back(mk(0, 0,1,1,0,  0, 0, 0, 1, 0, 1,   8'h5A, 25'h0000200, 8'h00));
        tbl.push_back(mk(0, 0,0,1,0,  0, 0, 0, 0, 0, 0,   8'h5A, 25'h0000200, 8'h00));
        tbl.push_back(mk(0, 0,0,1,0,  0, 1, 0, 0, 0, 1,   8'h5A, 25'h00066C8, 8'h99));
        tbl.push_back(mk(0, 0,0,1,0,  0, 1, 0, 0, 0, 1,   8'h5A, 25'h00066C8, 8'h99));
        tbl.push_back(mk(0, 0,0,1,0,  0, 1, 0, 0, 0, 1,   8'h5A, 25'h00066C8, 8'h99));
        tbl.push_back(mk(0, 0,0,1,0,  0, 1, 0, 0, 0, 1,   8'h5A, 25'h00066C8, 8'h99));
        tbl.push_back(mk(0, 0,0,1,0,  0, 0, 0, 0, 1, 1,   8'hA5, 25'h00066C8, 8'h99));
        tbl.push_back(mk(0, 0,0,0,0,  0, 0, 0, 0, 0, 0,   8'hA5, 25'h00066C8, 8'h99));

        for (int i = 0; i < tbl.size(); i++) begin
            RESET       = tbl[i].rst;
            bus.dio_req = tbl[i].dio;
            bus.vid_req = tbl[i].vid;
            bus.cpu_req = tbl[i].cpu;
            bus.cpu_wr  = tbl[i].wr;
            step();
            chk($sformatf("row%0d_sd_we", i),   {31'd0, bus.sd_we},   {31'd0, tbl[i].e_we});
            chk($sformatf("row%0d_sd_oe", i),   {31'd0, bus.sd_oe},   {31'd0, tbl[i].e_oe});
            chk($sformatf("row%0d_dio_ack", i), {31'd0, bus.dio_ack}, {31'd0, tbl[i].e_dack});
            chk($sformatf("row%0d_vid_ack", i), {31'd0, bus.vid_ack}, {31'd0, tbl[i].e_vack});
            chk($sformatf("row%0d_cpu_ack", i), {31'd0, bus.cpu_ack}, {31'd0, tbl[i].e_cack});
            chk($sformatf("row%0d_busy", i),    {31'd0, bus.busy},    {31'd0, tbl[i].e_busy});
            chk($sformatf("row%0d_rd_data", i), {24'd0, bus.rd_data}, {24'd0, tbl[i].e_rd});
            chk($sformatf("row%0d_sd_addr", i), {7'd0, bus.sd_addr},  {7'd0, tbl[i].e_addr});
            chk($sformatf("row%0d_sd_din", i),  {24'd0, bus.sd_din},  {24'd0, tbl[i].e_din});
        end
        chk("idle_state_after_table", {30'd0, dbg_state}, {30'd0, IDLE});

        // ------------------------------------------- reset in 2nd ACCESS cycle
        bus.cpu_addr = 25'h0000ABC;
        bus.cpu_din  = 8'h77;
        bus.cpu_wr   = 1'b1;
        bus.cpu_req  = 1'b1;
        step();
        chk("abort_we_cycle1", {31'd0, bus.sd_we}, 32'd1);
        step();
        chk("abort_we_cycle2", {31'd0, bus.sd_we}, 32'd1);
        chk("abort_addr", {7'd0, bus.sd_addr}, {7'd0, 25'h0000ABC});
        chk("abort_din", {24'd0, bus.sd_din}, 32'h77);
        RESET = 1'b1;
        step();
        chk("abort_we_low", {31'd0, bus.sd_we}, 32'd0);
        chk("abort_state_idle", {30'd0, dbg_state}, {30'd0, IDLE});
        chk("abort_busy_low", {31'd0, bus.busy}, 32'd0);
        chk("abort_addr_reset", {7'd0, bus.sd_addr}, 32'd0);
        chk("abort_rd_reset", {24'd0, bus.rd_data}, 32'd0);
        RESET       = 1'b0;
        bus.cpu_req = 1'b0;
        bus.cpu_wr  = 1'b0;
        ack_seen    = 0;
        repeat (10) begin
            step();
            if (bus.cpu_ack) ack_seen = 1;
        end
        chk("abort_no_cpu_ack", ack_seen, 0);

        // ------------------------------------------- download blocks the CPU
        bus.dio_addr = 25'h0000140;
        bus.dio_din  = 8'h11;
        bus.cpu_addr = 25'h00066C8;
        bus.dio_req  = 1'b1;
        bus.cpu_req  = 1'b1;
        dio_acks     = 0;
        cpu_seen     = 0;
        repeat (20) begin
            step();
            if (bus.dio_ack) dio_acks++;
            if (bus.cpu_ack) cpu_seen = 1;
        end
        chk("dio_block_dio_acks", dio_acks, 3);
        chk("dio_block_no_cpu_ack", cpu_seen, 0);
        // Wait (bounded) for the next download ack, then release download.
        k = 0;
        while (!bus.dio_ack && k < 8) begin
            step();
            if (bus.cpu_ack) cpu_seen = 1;
            k++;
        end
        chk("dio_block_next_ack_seen", {31'd0, bus.dio_ack}, 32'd1);
        chk("dio_block_no_cpu_ack2", cpu_seen, 0);
        bus.dio_req = 1'b0;
        // From the last download DONE: IDLE, grant, 3 more ACCESS, DONE.
        k = 0;
        while (!bus.cpu_ack && k < 12) begin
            step();
            k++;
        end
        chk("dio_release_cpu_latency", k, 6);
        chk("dio_release_cpu_rd", {24'd0, bus.rd_data}, 32'hA5);
        bus.cpu_req = 1'b0;
        step();
        chk("dio_release_idle", {31'd0, bus.busy}, 32'd0);

        // ------------------------------------------- video/CPU held together
        RESET = 1'b1;
        step();
        RESET = 1'b0;
`ifdef SDRAM_ARB_STARVE_EN
        for (int i = 0; i < 8; i++) exp_q.push_back(2'd1);
        exp_q.push_back(2'd2);
        exp_q.push_back(2'd1);
`else
        for (int i = 0; i < 10; i++) exp_q.push_back(2'd1);
`endif
        bus.vid_req = 1'b1;
        bus.cpu_req = 1'b1;
        repeat (60) begin
            step();
            if (bus.vid_ack || bus.cpu_ack) begin
                got = bus.cpu_ack ? 2'd2 : 2'd1;
                if (exp_q.size() == 0) begin
                    chk("grant_pattern_extra_ack", {30'd0, got}, 32'd0);
                end else begin
                    want = exp_q.pop_front();
                    chk("grant_pattern_owner", {30'd0, got}, {30'd0, want});
                end
            end
        end
        chk("grant_pattern_remaining", exp_q.size(), 0);
        bus.vid_req = 1'b0;
        bus.cpu_req = 1'b0;
        step();
        step();
        chk("final_idle", {30'd0, dbg_state}, {30'd0, IDLE});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
